// File: rtl/uart_tx_sched.sv
// uart_tx_sched: message-level round-robin scheduler that feeds single CPU bytes
// and 4-byte TRNG words into one byte-wide UART transmitter, one frame at a time.
module uart_tx_sched #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_valid,
    input  logic [7:0]  cpu_byte,
    output logic        cpu_ready,
    input  logic        rng_valid,
    input  logic [31:0] rng_word,
    output logic        rng_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_byte,
    input  logic        tx_active,
    input  logic        tx_done,
    output logic        busy,
    output logic        grant
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 3;

    localparam logic [CNT_W-1:0] CPU_BYTES = CNT_W'(1);
    localparam logic [CNT_W-1:0] RNG_BYTES = CNT_W'(4);
    localparam logic             OWNER_CPU = 1'b0;
    localparam logic             OWNER_RNG = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACT,
        WAIT_DONE,
        NEXT
    } state_t;

    state_t              state;
    logic [WORD_W-1:0]   buffer;
    logic [CNT_W-1:0]    count;
    logic                last_owner;
    logic                tx_done_q;

    logic                grant_ok;
    logic                rng_wins;
    logic                accept;
    logic                done_fall;
    logic                from_top;
    logic [WORD_W-1:0]   load_word;
    logic [WORD_W-1:0]   buf_shifted;
    logic [CNT_W-1:0]    count_dec;

    // Byte at the head of the buffer: top byte when draining MSB-first, else bottom byte.
    function automatic logic [BYTE_W-1:0] head_byte(input logic [WORD_W-1:0] w, input logic top);
        head_byte = top ? w[WORD_W-1 -: BYTE_W] : w[BYTE_W-1:0];
    endfunction

    // Advance the buffer by one byte in the draining direction.
    function automatic logic [WORD_W-1:0] drop_byte(input logic [WORD_W-1:0] w, input logic top);
        drop_byte = top ? (w << BYTE_W) : (w >> BYTE_W);
    endfunction

    // Arbitration, handshake and datapath helpers.
    always_comb begin
        grant_ok    = resetn && (state == IDLE) && !tx_active && !tx_done;
        rng_wins    = rng_valid && (!cpu_valid || (last_owner == OWNER_CPU));
        cpu_ready   = grant_ok && cpu_valid && !rng_wins;
        rng_ready   = grant_ok && rng_wins;
        accept      = cpu_ready || rng_ready;
        load_word   = rng_wins ? rng_word : WORD_W'(cpu_byte);
        done_fall   = tx_done_q && !tx_done;
        from_top    = MSB_FIRST && (grant == OWNER_RNG);
        buf_shifted = drop_byte(buffer, from_top);
        count_dec   = count - CNT_W'(1);
    end

    // Message FSM with registered transmitter-side outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            buffer     <= '0;
            count      <= '0;
            last_owner <= OWNER_RNG;
            grant      <= OWNER_CPU;
            tx_done_q  <= 1'b0;
            tx_valid   <= 1'b0;
            tx_byte    <= '0;
            busy       <= 1'b0;
        end else begin
            tx_done_q <= tx_done;
            tx_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        buffer     <= load_word;
                        count      <= rng_wins ? RNG_BYTES : CPU_BYTES;
                        grant      <= rng_wins;
                        last_owner <= rng_wins;
                        tx_valid   <= 1'b1;
                        tx_byte    <= head_byte(load_word, MSB_FIRST && rng_wins);
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT_ACT;
                end
                WAIT_ACT: begin
                    if (tx_active) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (done_fall) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    buffer <= buf_shifted;
                    count  <= count_dec;
                    if (count_dec == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        tx_valid <= 1'b1;
                        tx_byte  <= head_byte(buf_shifted, from_top);
                        state    <= ISSUE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: two instances (LSB-first and MSB-first byte order) share
// stimulus; a message-level reference model predicts handshakes, byte order and timing.
module tb_uart_tx_sched;

    logic        clk;
    logic        resetn;
    logic        cpu_valid;
    logic [7:0]  cpu_byte;
    logic        rng_valid;
    logic [31:0] rng_word;
    logic        tx_active;
    logic        tx_done;

    logic        cpu_ready0, rng_ready0, tx_valid0, busy0, grant0;
    logic [7:0]  tx_byte0;
    logic        cpu_ready1, rng_ready1, tx_valid1, busy1, grant1;
    logic [7:0]  tx_byte1;

    // transmitter model (m_*) and hand-driven (h_*) contributions
    logic m_active, m_done, h_active, h_done, model_en;
    assign tx_active = m_active | h_active;
    assign tx_done   = m_done | h_done;

    uart_tx_sched #(.MSB_FIRST(1'b0)) u_dut0 (
        .clk(clk), .resetn(resetn),
        .cpu_valid(cpu_valid), .cpu_byte(cpu_byte), .cpu_ready(cpu_ready0),
        .rng_valid(rng_valid), .rng_word(rng_word), .rng_ready(rng_ready0),
        .tx_valid(tx_valid0), .tx_byte(tx_byte0),
        .tx_active(tx_active), .tx_done(tx_done),
        .busy(busy0), .grant(grant0)
    );

    uart_tx_sched #(.MSB_FIRST(1'b1)) u_dut1 (
        .clk(clk), .resetn(resetn),
        .cpu_valid(cpu_valid), .cpu_byte(cpu_byte), .cpu_ready(cpu_ready1),
        .rng_valid(rng_valid), .rng_word(rng_word), .rng_ready(rng_ready1),
        .tx_valid(tx_valid1), .tx_byte(tx_byte1),
        .tx_active(tx_active), .tx_done(tx_done),
        .busy(busy1), .grant(grant1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: after each issued byte, random start delay, random frame length,
    // then tx_active drops and tx_done is high for exactly two cycles.
    initial begin : xmit_model
        int unsigned d;
        int unsigned len;
        m_active = 1'b0;
        m_done   = 1'b0;
        forever begin
            @(negedge clk);
            if (model_en && tx_valid0) begin
                d   = $urandom_range(1, 3);
                len = $urandom_range(1, 6);
                repeat (d) @(posedge clk);
                #1 m_active = 1'b1;
                repeat (len) @(posedge clk);
                #1;
                m_active = 1'b0;
                m_done   = 1'b1;
                repeat (2) @(posedge clk);
                #1 m_done = 1'b0;
            end
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    int         left       = 0;
    int         idle_from  = 0;
    int         next_valid = -1;
    logic       ref_last   = 1'b1;
    logic       ref_grant  = 1'b0;
    logic       prev_done  = 1'b0;
    logic [7:0] last_b0    = 8'h00;
    logic [7:0] last_b1    = 8'h00;
    logic       cpu_took   = 1'b0;
    logic       rng_took   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle reference check, sampled on the falling edge.
    task automatic monitor();
        logic ridle, en, e_cpu, e_rng, hit;
        logic [31:0] w;
        if (!resetn) begin
            chk("rst_tx_valid", 32'(tx_valid0), 32'(0));
            chk("rst_tx_byte", 32'(tx_byte0), 32'(0));
            chk("rst_busy", 32'(busy0), 32'(0));
            chk("rst_grant", 32'(grant0), 32'(0));
            chk("rst_ready", 32'({cpu_ready0, rng_ready0, cpu_ready1, rng_ready1}), 32'(0));
            exp_q0.delete();
            exp_q1.delete();
            left = 0; idle_from = 0; next_valid = -1;
            ref_last = 1'b1; ref_grant = 1'b0; prev_done = 1'b0;
            cpu_took = 1'b0; rng_took = 1'b0;
            return;
        end
        ridle = (left == 0) && (cyc >= idle_from);
        en    = ridle && !tx_active && !tx_done;
        e_cpu = en && cpu_valid && (!rng_valid || ref_last);
        e_rng = en && rng_valid && (!cpu_valid || !ref_last);
        chk("cpu_ready", 32'(cpu_ready0), 32'(e_cpu));
        chk("rng_ready", 32'(rng_ready0), 32'(e_rng));
        chk("ready_msb", 32'({cpu_ready1, rng_ready1}), 32'({e_cpu, e_rng}));
        chk("busy", 32'({busy0, busy1}), 32'({!ridle, !ridle}));
        chk("grant", 32'({grant0, grant1}), 32'({ref_grant, ref_grant}));
        hit = (cyc == next_valid);
        chk("tx_valid", 32'(tx_valid0), 32'(hit));
        chk("tx_valid_msb", 32'(tx_valid1), 32'(hit));
        if (hit) begin
            if (exp_q0.size() > 0) begin
                last_b0 = exp_q0.pop_front();
                last_b1 = exp_q1.pop_front();
            end
            chk("tx_byte_lsb", 32'(tx_byte0), 32'(last_b0));
            chk("tx_byte_msb", 32'(tx_byte1), 32'(last_b1));
            chk("tx_valid_vs_done", 32'(tx_done), 32'(0));
            next_valid = -1;
        end
        if (prev_done && !tx_done && left > 0) begin
            chk("tx_byte_hold", 32'({tx_byte0, tx_byte1}), 32'({last_b0, last_b1}));
            left--;
            if (left > 0) next_valid = cyc + 2;
            else          idle_from  = cyc + 2;
        end
        if (e_cpu) begin
            exp_q0.push_back(cpu_byte);
            exp_q1.push_back(cpu_byte);
            left = 1; next_valid = cyc + 1; ref_last = 1'b0; ref_grant = 1'b0;
        end
        if (e_rng) begin
            w = rng_word;
            for (int i = 0; i < 4; i++) begin
                exp_q0.push_back(w[8*i +: 8]);
                exp_q1.push_back(w[8*(3-i) +: 8]);
            end
            left = 4; next_valid = cyc + 1; ref_last = 1'b1; ref_grant = 1'b1;
        end
        prev_done = tx_done;
        cpu_took  = cpu_valid && cpu_ready0;
        rng_took  = rng_valid && rng_ready0;
    endtask

    // One clock: check on the falling edge, return just after the next rising edge.
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_take(input string name);
        int k;
        k = 0;
        while (!(cpu_took || rng_took) && k < 200) begin
            step();
            k++;
        end
        chk(name, 32'(cpu_took || rng_took), 32'(1));
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((busy0 || exp_q0.size() != 0 || tx_active || tx_done) && k < 1000) begin
            step();
            k++;
        end
        chk(name, 32'({busy0, exp_q0.size() != 0}), 32'(0));
    endtask

    typedef struct {
        logic        cv;
        logic        rv;
        logic [7:0]  cb;
        logic [31:0] rw;
        logic        exp_rng;
        logic [7:0]  first0;
        logic [7:0]  first1;
    } vec_t;

    vec_t vecs[8];

    initial begin : main
        int k;
        vecs[0] = '{1'b1, 1'b0, 8'hA5, 32'h0000_0000, 1'b0, 8'hA5, 8'hA5};
        vecs[1] = '{1'b0, 1'b1, 8'h00, 32'h1122_3344, 1'b1, 8'h44, 8'h11};
        vecs[2] = '{1'b1, 1'b1, 8'hC3, 32'h5566_7788, 1'b0, 8'hC3, 8'hC3};
        vecs[3] = '{1'b1, 1'b1, 8'h3C, 32'hDEAD_BEEF, 1'b1, 8'hEF, 8'hDE};
        vecs[4] = '{1'b1, 1'b1, 8'h96, 32'h0102_0304, 1'b0, 8'h96, 8'h96};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 32'h8899_AABB, 1'b1, 8'hBB, 8'h88};
        vecs[6] = '{1'b0, 1'b1, 8'h00, 32'hCAFE_F00D, 1'b1, 8'h0D, 8'hCA};
        vecs[7] = '{1'b1, 1'b0, 8'h7E, 32'h0000_0000, 1'b0, 8'h7E, 8'h7E};

        resetn = 1'b0; cpu_valid = 1'b0; cpu_byte = 8'h00;
        rng_valid = 1'b0; rng_word = 32'h0;
        h_active = 1'b0; h_done = 1'b0; model_en = 1'b1;
        repeat (3) step();
        resetn = 1'b1;
        repeat (2) step();

        // directed message table
        for (int i = 0; i < 8; i++) begin
            cpu_valid = vecs[i].cv; cpu_byte = vecs[i].cb;
            rng_valid = vecs[i].rv; rng_word = vecs[i].rw;
            wait_take("vec_accept_timeout");
            chk("vec_owner", 32'(rng_took), 32'(vecs[i].exp_rng));
            cpu_valid = 1'b0; rng_valid = 1'b0;
            chk("vec_first_valid", 32'({tx_valid0, tx_valid1}), 32'(2'b11));
            chk("vec_first_lsb", 32'(tx_byte0), 32'(vecs[i].first0));
            chk("vec_first_msb", 32'(tx_byte1), 32'(vecs[i].first1));
            drain("vec_drain");
        end

        // randomized traffic with data scrambled while waiting for ready
        for (int c = 0; c < 4000; c++) begin
            step();
            if (cpu_took) cpu_valid = 1'b0;
            if (rng_took) rng_valid = 1'b0;
            if (!cpu_valid && $urandom_range(0, 3) == 0) cpu_valid = 1'b1;
            if (!rng_valid && $urandom_range(0, 5) == 0) rng_valid = 1'b1;
            if ($urandom_range(0, 1) == 1) cpu_byte = 8'($urandom);
            if ($urandom_range(0, 1) == 1) rng_word = $urandom;
        end
        cpu_valid = 1'b0; rng_valid = 1'b0;
        drain("rand_drain");

        // reset in the middle of the second TRNG byte, transmitter still active
        model_en = 1'b0;
        step();
        rng_valid = 1'b1; rng_word = 32'hA1B2_C3D4;
        wait_take("r35_accept_timeout");
        rng_valid = 1'b0;
        step();
        h_active = 1'b1;
        repeat (3) step();
        h_active = 1'b0; h_done = 1'b1;
        repeat (2) step();
        h_done = 1'b0;
        k = 0;
        while (!tx_valid0 && k < 10) begin
            step();
            k++;
        end
        chk("r35_byte2_valid", 32'(tx_valid0), 32'(1));
        chk("r35_byte2", 32'(tx_byte0), 32'(8'hC3));
        step();
        h_active = 1'b1; cpu_valid = 1'b1; cpu_byte = 8'h5A;
        repeat (2) step();
        resetn = 1'b0;
        #1;
        chk("r35_async_tx_valid", 32'(tx_valid0), 32'(0));
        chk("r35_async_busy", 32'(busy0), 32'(0));
        chk("r35_async_tx_byte", 32'(tx_byte0), 32'(0));
        chk("r35_async_ready", 32'({cpu_ready0, rng_ready0}), 32'(0));
        step();
        resetn = 1'b1;
        repeat (3) begin
            step();
            chk("r35_hold_active", 32'(cpu_ready0), 32'(0));
        end
        h_active = 1'b0; h_done = 1'b1;
        step();
        chk("r35_hold_done", 32'(cpu_ready0), 32'(0));
        step();
        chk("r35_hold_done2", 32'(cpu_ready0), 32'(0));
        h_done = 1'b0; model_en = 1'b1;
        wait_take("r35_cpu_timeout");
        chk("r35_cpu_grant", 32'(cpu_took), 32'(1));
        cpu_valid = 1'b0;
        chk("r35_cpu_byte", 32'(tx_byte0), 32'(8'h5A));
        drain("r35_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter: MSB_FIRST, default 0, byte order of a serialised 32-bit word (0 = byte[7:0] first, 1 = byte[31:24] first).
REQ-002 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port: resetn  input  1  asynchronous, active-low reset.
REQ-004 Port: cpu_valid  input  1  CPU requester has one byte to send.
REQ-005 Port: cpu_byte  input  8  CPU byte; sampled on the cpu_valid && cpu_ready cycle.
REQ-006 Port: cpu_ready  output  1  CPU byte accepted this cycle.
REQ-007 Port: rng_valid  input  1  TRNG requester has one 32-bit word to send.
REQ-008 Port: rng_word  input  32  TRNG word; sampled on the rng_valid && rng_ready cycle.
REQ-009 Port: rng_ready  output  1  TRNG word accepted this cycle.
REQ-010 Port: tx_valid  output  1  drives the transmitter's data_valid input.
REQ-011 Port: tx_byte  output  8  drives the transmitter's tx_byte input.
REQ-012 Port: tx_active  input  1  transmitter tx_active.
REQ-013 Port: tx_done  input  1  transmitter tx_done; high for 2 consecutive cycles at the end of each frame.
REQ-014 Port: busy  output  1  a message is in progress (state != IDLE).
REQ-015 Port: grant  output  1  current or last owner: 0 = CPU, 1 = TRNG.

Function
REQ-016 States SHALL be IDLE, ISSUE, WAIT_ACT, WAIT_DONE and NEXT, held in a registered FSM.
REQ-017 IDLE: a grant SHALL occur only when tx_active==0 and tx_done==0 and at least one valid is high.
REQ-018 Arbitration SHALL be round-robin at message granularity: on a tie, the requester not served last wins; a single requester always wins.
REQ-019 cpu_ready/rng_ready SHALL be combinational, high only in IDLE with the REQ-017 condition met, for the winner only; they are never both high.
REQ-020 On acceptance the block SHALL latch the byte or word into a 32-bit buffer, set remaining count to 1 (CPU) or 4 (TRNG), update grant/last-owner, and go to ISSUE.
REQ-021 ISSUE: tx_valid SHALL be 1 for exactly this one cycle, with tx_byte = current buffer byte (per MSB_FIRST for TRNG, buffer[7:0] for CPU); next state WAIT_ACT.
REQ-022 tx_byte SHALL stay stable from ISSUE until the following NEXT state.
REQ-023 WAIT_ACT: the block SHALL wait for tx_active==1, then go to WAIT_DONE; tx_valid is 0.
REQ-024 WAIT_DONE: the block SHALL detect the tx_done falling edge (registered tx_done==1 and current tx_done==0), then go to NEXT; the rising edge alone SHALL NOT advance.
REQ-025 NEXT: the block SHALL decrement the count and shift the buffer by 8 bits toward the next byte; if the new count is 0 it goes to IDLE, otherwise to ISSUE.
REQ-026 Latency: acceptance in cycle N gives tx_valid in cycle N+1; tx_done falling in cycle M gives the next tx_valid in cycle M+2.
REQ-027 Requests arriving while busy SHALL be held off (ready low) and never dropped or merged; a message is never interrupted by the other requester.
REQ-028 Input changes on valid/data while ready is low SHALL have no effect on the buffer.

Reset
REQ-029 On resetn low the block SHALL asynchronously force: state IDLE, tx_valid 0, tx_byte 8'h00, cpu_ready 0, rng_ready 0, busy 0, grant 0, count 0, buffer 0, last-owner = TRNG (so the CPU wins the first tie), registered tx_done 0.
REQ-030 Reset mid-message SHALL discard remaining bytes; after release, no grant SHALL occur until the transmitter reports tx_active==0 and tx_done==0.

Verification
REQ-031 CPU only: cpu_valid with cpu_byte=8'hA5 -> cpu_ready for 1 cycle, one tx_valid pulse with tx_byte=8'hA5, busy drops the cycle after the tx_done falling edge is handled.
REQ-032 TRNG with MSB_FIRST=0: rng_word=32'h11223344 -> 4 frames in order 44,33,22,11, exactly one tx_valid per frame; MSB_FIRST=1 -> order 11,22,33,44.
REQ-033 Tie after reset: cpu_valid and rng_valid both high -> CPU served first, then TRNG; repeated ties alternate CPU, TRNG, CPU.
REQ-034 Two-cycle tx_done: tx_valid SHALL NOT assert while tx_done==1; the next tx_valid follows the falling edge by exactly 2 cycles.
REQ-035 resetn pulsed during the 2nd TRNG byte, with tx_active still 1 -> outputs at reset values immediately; a pending cpu_valid is granted only after tx_active and tx_done both read 0.
